// File: rtl/mem_responder_if.sv
// mem_responder_if: load/store request/response bundle between the CPU and mem_responder.
//   req_valid/req_ready   request handshake (CPU -> responder)
//   req_write             1 = store, 0 = load
//   req_addr  [31:0]      byte address
//   req_wdata [31:0]      store data (low byte/half for SB/SH)
//   req_width [2:0]       funct3 access width code
//   resp_valid/resp_ready response handshake (responder -> CPU)
//   resp_rdata [31:0]     extended load data, 0 for stores and errors
//   resp_err              misaligned access or illegal width code
// Modports: master (CPU side), slave (responder side).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_width;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_width, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_width, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle byte-addressed data memory, target end of the CPU load/store port.
// Accepts one request at a time, holds it LATENCY cycles, then commits the store or returns
// sign/zero-extended load data through a registered response handshake.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   mem_responder_if.slave (request/response handshake and data)
//   ioin  external input word, only read when MMIO_IN_EN is defined
// Optional feature macro: MMIO_IN_EN -- loads of the IO_ADDR word return ioin and stores to
// that word are acknowledged and discarded. Without it IO_ADDR is ordinary RAM.
// ADDR_WIDTH must be below 32; LATENCY must be 1..15.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] IO_ADDR    = 32'h0001_FFFC
) (
  input  logic              clk,
  input  logic              rst,
  mem_responder_if.slave    bus,
  input  logic [31:0]       ioin
);

  localparam int unsigned MemBytes = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  LatM1    = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state;
  logic [3:0]              cnt;
  logic                    lat_write;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [31:0]             lat_wdata;
  logic [2:0]              lat_width;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic                    resp_err_q;
  logic [31:0]             resp_rdata_q;

  logic [7:0]              mem [MemBytes];

  logic                    cur_write;
  logic [ADDR_WIDTH-1:0]   a0, a1, a2, a3;
  logic [31:0]             cur_wdata;
  logic [2:0]              cur_width;
  logic                    err_d;
  logic                    io_hit;
  logic [31:0]             raw_word;
  logic [31:0]             rdata_d;
  logic                    idle_commit;
  logic                    commit;
  logic                    mem_we;

  logic                    unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_WIDTH];

  // Live inputs are only consumed directly when LATENCY==1 (commit on the accepting edge).
  always_comb begin
    cur_write = lat_write;
    a0        = lat_addr;
    cur_wdata = lat_wdata;
    cur_width = lat_width;
    if (state == StIdle) begin
      cur_write = bus.req_write;
      a0        = bus.req_addr[ADDR_WIDTH-1:0];
      cur_wdata = bus.req_wdata;
      cur_width = bus.req_width;
    end
    a1 = a0 + ADDR_WIDTH'(1);
    a2 = a0 + ADDR_WIDTH'(2);
    a3 = a0 + ADDR_WIDTH'(3);
  end

  always_comb begin
    err_d = 1'b0;
    if (cur_width inside {3'b011, 3'b110, 3'b111}) err_d = 1'b1;
    if (cur_width[1:0] == 2'b01 && a0[0]) err_d = 1'b1;
    if (cur_width[1:0] == 2'b10 && a0[1:0] != 2'b00) err_d = 1'b1;
  end

`ifdef MMIO_IN_EN
  assign io_hit = (a0[ADDR_WIDTH-1:2] == IO_ADDR[ADDR_WIDTH-1:2]);
`else
  logic unused_io;
  assign unused_io = ^{ioin, IO_ADDR};
  assign io_hit    = 1'b0;
`endif

  always_comb begin
    raw_word = {mem[a3], mem[a2], mem[a1], mem[a0]};
`ifdef MMIO_IN_EN
    if (io_hit) raw_word = ioin >> {a0[1:0], 3'b000};
`endif
    rdata_d = 32'h0;
    if (!err_d && !cur_write) begin
      case (cur_width)
        3'b000:  rdata_d = {{24{raw_word[7]}}, raw_word[7:0]};
        3'b001:  rdata_d = {{16{raw_word[15]}}, raw_word[15:0]};
        3'b010:  rdata_d = raw_word;
        3'b100:  rdata_d = {24'h0, raw_word[7:0]};
        3'b101:  rdata_d = {16'h0, raw_word[15:0]};
        default: rdata_d = 32'h0;
      endcase
    end
  end

  // Only a zero-latency-to-RESP build can commit straight from IDLE; rst gates it so a
  // request presented during reset is dropped.
  if (LATENCY == 1) begin : g_lat1
    assign idle_commit = rst && (state == StIdle) && bus.req_valid;
  end else begin : g_latn
    assign idle_commit = 1'b0;
  end

  assign commit = idle_commit || (state == StBusy && cnt == 4'd1);
  assign mem_we = commit && cur_write && !err_d && !io_hit;

  // RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[a0] <= cur_wdata[7:0];
      if (cur_width[1:0] != 2'b00) mem[a1] <= cur_wdata[15:8];
      if (cur_width[1:0] == 2'b10) begin
        mem[a2] <= cur_wdata[23:16];
        mem[a3] <= cur_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StIdle;
      cnt          <= 4'd0;
      lat_write    <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= 32'h0;
      lat_width    <= 3'b000;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (bus.req_valid) begin
            lat_write   <= bus.req_write;
            lat_addr    <= bus.req_addr[ADDR_WIDTH-1:0];
            lat_wdata   <= bus.req_wdata;
            lat_width   <= bus.req_width;
            cnt         <= LatM1;
            req_ready_q <= 1'b0;
            if (LATENCY > 1) begin
              state <= StBusy;
            end else begin
              state        <= StResp;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= rdata_d;
              resp_err_q   <= err_d;
            end
          end
        end
        StBusy: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state        <= StResp;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rdata_d;
            resp_err_q   <= err_d;
          end
        end
        StResp: begin
          if (bus.resp_ready) begin
            state        <= StIdle;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule
